// File: rtl/mul_datapath_if.sv
// Handshake bundle between the multiplier controller and its datapath.
// The controller side drives the strobes and operand; the datapath returns status and product.
interface mul_datapath_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0]   data_in;
    logic               lda;
    logic               ldb;
    logic               decb;
    logic               eq;
    logic [2*WIDTH-1:0] result;
    logic               result_valid;
    logic               busy;

    modport master (
        output data_in, lda, ldb, decb,
        input  eq, result, result_valid, busy
    );

    modport slave (
        input  data_in, lda, ldb, decb,
        output eq, result, result_valid, busy
    );
endinterface

// File: rtl/mul_datapath.sv
// Repeated-addition multiplier datapath: multiplicand A, down-counter B, accumulator P,
// plus a held result register that is written once per finished product.
module mul_datapath #(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    mul_datapath_if.slave  bus
);
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2*WIDTH-1:0] p;
    logic [2*WIDTH-1:0] result;
    logic               result_valid;
    logic               armed;
    logic               b_zero;

    assign b_zero = (b == '0);

    // Capture is listed before Load B so that a simultaneous Load B re-arms;
    // the capture still takes the pre-edge P because of non-blocking semantics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a            <= '0;
            b            <= '0;
            p            <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            armed        <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (bus.lda) begin
                a <= bus.data_in;
            end
            if (armed && b_zero) begin
                result       <= p;
                result_valid <= 1'b1;
                armed        <= 1'b0;
            end
            if (bus.ldb && !bus.decb) begin
                b     <= bus.data_in;
                p     <= '0;
                armed <= 1'b1;
            end else if (bus.ldb && bus.decb && !b_zero) begin
                p <= p + {{WIDTH{1'b0}}, a};
                b <= b - 1'b1;
            end
        end
    end

    assign bus.eq           = b_zero;
    assign bus.result       = result;
    assign bus.result_valid = result_valid;
    assign bus.busy         = armed;
endmodule

// File: doc/mul_datapath.md
# mul_datapath

Datapath half of the repeated-addition multiplier. It holds multiplicand A, down-counter B and accumulator P. It consumes the `lda`/`ldb`/`decb` strobes issued by the multiplier controller and returns the `eq` status that drives the controller's state transitions. The block captures each finished product into a held result register with a one-cycle valid pulse, so control strobes issued after completion cannot corrupt the answer.

## Interface
- `WIDTH`, default 16: operand width; product and accumulator are 2*WIDTH.
- `clk`  input  1  rising-edge clock, single clock domain.
- `rst_n`  input  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- `data_in`  input  WIDTH  operand bus, shared by A and B loads.
- `lda`  input  1  load A from `data_in`.
- `ldb`  input  1  with `decb`=0: load B from `data_in` and clear P. With `decb`=1: accumulate step.
- `decb`  input  1  qualifies `ldb` as an accumulate step; ignored when `ldb`=0.
- `eq`  output  1  combinational, (B == 0).
- `result`  output  2*WIDTH  last captured product, held until the next capture.
- `result_valid`  output  1  one-cycle pulse on each capture.
- `busy`  output  1  registered; equals the armed flag.

## Operation
- Registers: A[WIDTH], B[WIDTH], P[2*WIDTH], result[2*WIDTH], result_valid, armed.
- Reset (async, `rst_n`=0):
  - A, B, P and result are set to 0.
  - result_valid and armed are set to 0.
  - `eq` reads 1 during and after reset, because B=0.
- Per rising edge, all decisions use pre-edge register values:
  - **Load A:** if `lda`, then A <= `data_in`. This is independent of the B/P actions.
  - **Load B:** if `ldb` && !`decb`, then B <= `data_in`, P <= 0, armed <= 1.
  - **Accumulate:** if `ldb` && `decb` && B != 0, then P <= P + A and B <= B - 1.
    - P + A is computed in 2*WIDTH bits with A zero-extended. No overflow is possible because P never exceeds A*B_initial.
  - **Suppressed step:** if `ldb` && `decb` && B == 0, there is no change. B does not wrap and P holds.
  - **Capture:** if armed && B == 0, then result <= P, result_valid <= 1, armed <= 0. If the same edge also performs a Load B, armed <= 1 wins. The capture still uses the pre-edge P.
  - result_valid is 0 on every edge that does not capture.
- Simultaneous `lda` and `ldb`&!`decb`: both registers take the same `data_in`.
- `lda` during accumulation: the new A is used from the next step onward. This is legal; no protection is applied.
- Idle strobes (`decb` without `ldb`) are ignored.

## Timing
- Load B is at edge t0 with value n.
- The accumulate steps occur at edges t1..tn, one per cycle while the controller holds `ldb`=`decb`=1.
- `eq` rises combinationally after edge tn, so the controller sees it in the same cycle.
- Capture occurs at edge tn+1. result_valid is high for exactly the cycle following tn+1.
  - Total latency: n+2 edges from Load B to the valid cycle.
- n = 0: `eq` is high right after t0, capture is at t1, and result is 0.
- Gaps in the strobes (`ldb`=0 for some cycles) stall accumulation. Capture still waits for B==0.
- The controller's post-done Load B (`ldb`=1, `decb`=0) clears P and re-arms. result holds the previous product until the next capture.
- Reset mid-operation: all state clears immediately and asynchronously. No capture or pulse follows.
  - After release, the block is idle with `eq`=1 and `busy`=0.

## Test plan
- **5 x 3 (WIDTH=16):** `lda` with 5, Load B with 3, then 3 accumulate strobes.
  - `eq` rises after the 3rd step.
  - result=15 with a 1-cycle result_valid, 5 edges after Load B.
- **7 x 0:** `lda` 7, Load B 0.
  - `eq`=1 immediately.
  - result=0 with result_valid at the edge after Load B+1. P is never added.
- **WIDTH=8, 255 x 255:** 255 accumulate steps.
  - result=16'hFE01. B stops at 0.
  - 4 extra `ldb`&`decb` strobes leave P and B unchanged, and produce no second pulse.
- **Reset mid-operation:** Load B 10 with A=9, then 4 steps (P=36), then pull `rst_n` low mid-cycle.
  - All outputs go to 0 at once, `eq`=1.
  - No result_valid follows after release.
- **Controller-style tail:** after a 6 x 4 capture (result=24), apply `ldb`=1, `decb`=0 with `data_in`=2.
  - P clears and `busy`=1.
  - result stays 24 until the next capture.
- **Mid-run A change:** A=3, B=4. After 2 steps set A=10.
  - result = 3+3+10+10 = 26.
